id_issue_buffer: RTL

Decoupling FIFO between the decode stage (`id_stage`) and `issue_stage`. It takes decoded `scoreboard_entry_t` instructions with their control-flow flag, buffers up to `DEPTH` of them, and presents them in order to the issue stage's valid/ack input. It also enforces a single-outstanding-branch hold: after a control-flow instruction leaves, output is blocked until the execute stage resolves that branch. The block absorbs decode bursts and removes the combinational ack path from issue back into decode.

---
 rtl/id_issue_buffer_if.sv | 55 +++++
 rtl/id_issue_buffer.sv | 113 +++++++++++
 2 files changed

// File: rtl/id_issue_buffer_if.sv
// id_issue_buffer_if
//   Shared types plus the bundled handshake between decode, the issue
//   buffer and the issue stage.
//   Package id_issue_buffer_pkg : scoreboard_entry_t (decoded instruction).
//   Interface id_issue_buffer_if #(DEPTH):
//     decode side : decoded_instr_i, decoded_instr_valid_i, is_ctrl_flow_i,
//                   decoded_instr_ack_o
//     issue side  : issue_instr_o, issue_instr_valid_o, is_ctrl_flow_o,
//                   issue_ack_i
//     control     : flush_i, flush_unissued_instr_i, resolve_branch_i
//     status      : usage_o, full_o, empty_o
//   Modport slave is the buffer's view; master is the surrounding pipeline.

package id_issue_buffer_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  fu;
    logic [4:0]  rd;
  } scoreboard_entry_t;
endpackage

interface id_issue_buffer_if #(parameter int DEPTH = 4);
  import id_issue_buffer_pkg::*;

  logic                     flush_i;
  logic                     flush_unissued_instr_i;
  scoreboard_entry_t        decoded_instr_i;
  logic                     decoded_instr_valid_i;
  logic                     is_ctrl_flow_i;
  logic                     decoded_instr_ack_o;
  scoreboard_entry_t        issue_instr_o;
  logic                     issue_instr_valid_o;
  logic                     is_ctrl_flow_o;
  logic                     issue_ack_i;
  logic                     resolve_branch_i;
  logic [$clog2(DEPTH):0]   usage_o;
  logic                     full_o;
  logic                     empty_o;

  modport slave (
    input  flush_i, flush_unissued_instr_i, decoded_instr_i,
           decoded_instr_valid_i, is_ctrl_flow_i, issue_ack_i,
           resolve_branch_i,
    output decoded_instr_ack_o, issue_instr_o, issue_instr_valid_o,
           is_ctrl_flow_o, usage_o, full_o, empty_o
  );

  modport master (
    output flush_i, flush_unissued_instr_i, decoded_instr_i,
           decoded_instr_valid_i, is_ctrl_flow_i, issue_ack_i,
           resolve_branch_i,
    input  decoded_instr_ack_o, issue_instr_o, issue_instr_valid_o,
           is_ctrl_flow_o, usage_o, full_o, empty_o
  );
endinterface

// File: rtl/id_issue_buffer.sv
// id_issue_buffer
//   In-order FIFO between decode and issue. Buffers up to DEPTH decoded
//   instructions with their control-flow flag and blocks further issue after
//   a control-flow instruction leaves, until the branch is resolved.
//   Ports:
//     clk_i  : clock
//     rst_i  : synchronous active-high reset
//     bus    : id_issue_buffer_if.slave (decode/issue handshakes, flushes,
//              branch resolve, usage/full/empty status)
//   Optional feature: define ID_ISSUE_BUF_BYPASS_EN to let an incoming
//   instruction be presented to issue in the same cycle when the FIFO is
//   empty and not held.

module id_issue_buffer
  import id_issue_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic              clk_i,
  input logic              rst_i,
  id_issue_buffer_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    scoreboard_entry_t instr;
    logic              ctrl_flow;
  } fifo_entry_t;

  fifo_entry_t      mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             branch_pending_q;

  logic flush_any;
  logic full;
  logic empty;
  logic ack;
  logic fifo_valid;
  logic pop;
  logic bypass;
  logic bypass_take;
  logic push_write;
  logic set_hold;

  // Handshake decisions. Ack looks only at the registered full state, so a
  // same-cycle pop never makes room for a push into a full FIFO. Reset
  // also blocks ack so nothing is accepted while state is being cleared.
  always_comb begin
    flush_any  = bus.flush_i | bus.flush_unissued_instr_i;
    full       = (count_q == CNT_W'(DEPTH));
    empty      = (count_q == '0);
    ack        = bus.decoded_instr_valid_i & ~full & ~flush_any & ~rst_i;
    fifo_valid = ~empty & ~branch_pending_q;
    pop        = fifo_valid & bus.issue_ack_i & ~flush_any;
`ifdef ID_ISSUE_BUF_BYPASS_EN
    bypass     = empty & ~branch_pending_q & ~flush_any & ~rst_i
               & bus.decoded_instr_valid_i;
`else
    bypass     = 1'b0;
`endif
    // A bypassed instruction consumed this cycle never touches storage.
    bypass_take = bypass & bus.issue_ack_i;
    push_write  = ack & ~bypass_take;
    set_hold    = (pop & mem_q[rd_ptr_q].ctrl_flow)
                | (bypass_take & bus.is_ctrl_flow_i);
  end

  assign bus.decoded_instr_ack_o = ack;
  assign bus.issue_instr_valid_o = fifo_valid | bypass;
  assign bus.issue_instr_o       = bypass ? bus.decoded_instr_i
                                          : mem_q[rd_ptr_q].instr;
  assign bus.is_ctrl_flow_o      = bypass ? bus.is_ctrl_flow_i
                                          : mem_q[rd_ptr_q].ctrl_flow;
  assign bus.usage_o             = count_q;
  assign bus.full_o              = full;
  assign bus.empty_o             = empty;

  // Pointers and occupancy. Pointers wrap naturally because DEPTH is a
  // power of two; either flush empties the FIFO in one cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_any) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_write) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push_write && !pop)      count_q <= count_q + CNT_W'(1);
      else if (pop && !push_write) count_q <= count_q - CNT_W'(1);
    end
  end

  // Branch hold. Only the full flush clears it; a set in the same cycle as
  // a resolve wins because the resolve belongs to the older branch.
  always_ff @(posedge clk_i) begin
    if (rst_i || bus.flush_i)     branch_pending_q <= 1'b0;
    else if (set_hold)            branch_pending_q <= 1'b1;
    else if (bus.resolve_branch_i) branch_pending_q <= 1'b0;
  end

  // Storage is not reset; only the pointers decide what is valid.
  always_ff @(posedge clk_i) begin
    if (push_write) begin
      mem_q[wr_ptr_q] <= '{instr: bus.decoded_instr_i,
                           ctrl_flow: bus.is_ctrl_flow_i};
    end
  end

endmodule
